// File: rtl/serial_frame_tx_pkg.sv
// Shared field widths, line idle level and transmitter state encoding.
// Also consumed by the downstream receiver datapath, so keep encodings stable.
package serial_frame_tx_pkg;

    localparam int PORT_W = 2;
    localparam int LEN_W  = 4;
    localparam int DATA_W = 15;

    localparam logic IDLE_LEVEL = 1'b1;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        PORT  = 3'd2,
        LEN   = 3'd3,
        DATA  = 3'd4,
        FIN   = 3'd5
    } tx_state_t;

endpackage

// File: rtl/serial_frame_tx_if.sv
// Request/status bundle between a frame source and the serial transmitter.
// The transmitter takes the slave view; the requester drives through master.
interface serial_frame_tx_if;
    import serial_frame_tx_pkg::*;

    logic              clkEn;
    logic              start;
    logic [PORT_W-1:0] portNum;
    logic [LEN_W-1:0]  dataLen;
    logic [DATA_W-1:0] dataIn;
    logic              serOut;
    logic              busy;
    logic              done;
    logic [LEN_W-1:0]  bitsLeft;

    modport slave (
        input  clkEn, start, portNum, dataLen, dataIn,
        output serOut, busy, done, bitsLeft
    );

    modport master (
        output clkEn, start, portNum, dataLen, dataIn,
        input  serOut, busy, done, bitsLeft
    );

endinterface

// File: rtl/serial_frame_tx_shreg.sv
// frame_shreg: parallel-load, enable-gated shift register; o_head is the next bit to send.
// Zeros fill behind the shifted bits; load wins over shift, reset wins over both.
module frame_shreg #(
    parameter int WIDTH     = 4,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_load_dat,
    input  logic             i_shift,
    output logic             o_head
);

    logic [WIDTH-1:0] r_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_q <= '0;
        end else if (i_load) begin
            r_q <= i_load_dat;
        end else if (i_shift) begin
            if (MSB_FIRST) begin
                r_q <= {r_q[WIDTH-2:0], 1'b0};
            end else begin
                r_q <= {1'b0, r_q[WIDTH-1:1]};
            end
        end
    end

    assign o_head = MSB_FIRST ? r_q[WIDTH-1] : r_q[0];

endmodule

// File: rtl/serial_frame_tx.sv
// Serial frame transmitter: start bit, port (MSB first), length (MSB first), payload (LSB first).
// One bit per clkEn edge; the done pulse in FIN is one plain clk wide and ignores clkEn.
module serial_frame_tx
    import serial_frame_tx_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    serial_frame_tx_if.slave bus
);

    tx_state_t        r_state;
    logic [1:0]       r_cnt;
    logic [LEN_W-1:0] r_len;
    logic             r_ser;
    logic             r_busy;
    logic             r_done;
    logic [LEN_W-1:0] r_bits;

    logic w_en;
    logic w_accept;
    logic w_port_head;
    logic w_len_head;
    logic w_data_head;
    logic w_port_sh;
    logic w_len_sh;
    logic w_data_sh;

    assign w_en     = bus.clkEn;
    assign w_accept = (r_state == IDLE) && w_en && bus.start;

    // Each field register shifts on the same edge that puts its head bit on the line.
    assign w_port_sh = w_en && ((r_state == START) || (r_state == PORT && r_cnt != 2'd0));
    assign w_len_sh  = w_en && ((r_state == PORT && r_cnt == 2'd0) ||
                                (r_state == LEN && r_cnt != 2'd0));
    assign w_data_sh = w_en && ((r_state == LEN && r_cnt == 2'd0 && r_len != '0) ||
                                (r_state == DATA && r_bits != 4'd1));

    frame_shreg #(.WIDTH(PORT_W), .MSB_FIRST(1'b1)) u_port_sr (
        .clk        (clk),
        .rst        (rst),
        .i_load     (w_accept),
        .i_load_dat (bus.portNum),
        .i_shift    (w_port_sh),
        .o_head     (w_port_head)
    );

    frame_shreg #(.WIDTH(LEN_W), .MSB_FIRST(1'b1)) u_len_sr (
        .clk        (clk),
        .rst        (rst),
        .i_load     (w_accept),
        .i_load_dat (bus.dataLen),
        .i_shift    (w_len_sh),
        .o_head     (w_len_head)
    );

    frame_shreg #(.WIDTH(DATA_W), .MSB_FIRST(1'b0)) u_data_sr (
        .clk        (clk),
        .rst        (rst),
        .i_load     (w_accept),
        .i_load_dat (bus.dataIn),
        .i_shift    (w_data_sh),
        .o_head     (w_data_head)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_cnt   <= 2'd0;
            r_len   <= '0;
            r_ser   <= IDLE_LEVEL;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_bits  <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_state <= START;
                        r_len   <= bus.dataLen;
                        r_ser   <= 1'b0;
                        r_busy  <= 1'b1;
                    end
                end
                START: begin
                    if (w_en) begin
                        r_state <= PORT;
                        r_cnt   <= 2'(PORT_W - 1);
                        r_ser   <= w_port_head;
                    end
                end
                PORT: begin
                    if (w_en) begin
                        if (r_cnt != 2'd0) begin
                            r_cnt <= r_cnt - 2'd1;
                            r_ser <= w_port_head;
                        end else begin
                            r_state <= LEN;
                            r_cnt   <= 2'(LEN_W - 1);
                            r_ser   <= w_len_head;
                        end
                    end
                end
                LEN: begin
                    if (w_en) begin
                        if (r_cnt != 2'd0) begin
                            r_cnt <= r_cnt - 2'd1;
                            r_ser <= w_len_head;
                        end else if (r_len != '0) begin
                            r_state <= DATA;
                            r_ser   <= w_data_head;
                            r_bits  <= r_len;
                        end else begin
                            r_state <= FIN;
                            r_ser   <= IDLE_LEVEL;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                        end
                    end
                end
                DATA: begin
                    if (w_en) begin
                        r_bits <= r_bits - 4'd1;
                        if (r_bits == 4'd1) begin
                            r_state <= FIN;
                            r_ser   <= IDLE_LEVEL;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                        end else begin
                            r_ser <= w_data_head;
                        end
                    end
                end
                FIN: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign bus.serOut   = r_ser;
    assign bus.busy     = r_busy;
    assign bus.done     = r_done;
    assign bus.bitsLeft = r_bits;

endmodule

// File: doc/serial_frame_tx.md
SERIAL_FRAME_TX -- requirements
Module: serial_frame_tx

Interface
REQ-001 SHALL have ports, one per line, as follows; clock and reset come first.
- clk  input  1  single system clock; all state updates on rising edge.
- rst  input  1  reset; synchronous, active-high.
- clkEn  input  1  bit-rate enable; state advances only on edges where clkEn=1.
- start  input  1  request to send one frame.
- portNum  input  2  destination port 0..3.
- dataLen  input  4  number of payload bits, 0..15.
- dataIn  input  15  payload; bit 0 is sent first.
- serOut  output  1  serial line; idles high.
- busy  output  1  high from start acceptance until frame end.
- done  output  1  one-clk pulse after the last bit.
- bitsLeft  output  4  payload bits not yet sent, for SSD display.
REQ-002 SHALL have no parameters; all field widths are fixed.

Function
REQ-003 Frame format SHALL be, one bit per enabled cycle:
- start bit 0;
- portNum, 2 bits, MSB first;
- dataLen, 4 bits, MSB first;
- dataLen payload bits, dataIn[0] first.
REQ-004 FSM states SHALL be IDLE, START, PORT, LEN, DATA, FIN.
REQ-005 In IDLE, an edge with start=1 and clkEn=1 SHALL accept the request.
- On acceptance, latch portNum, dataLen and dataIn.
- Enter START; serOut=0 and busy=1 from that edge.
REQ-006 start while busy=1, or with clkEn=0, SHALL be ignored; no queuing.
REQ-007 Each enabled edge SHALL advance exactly one bit.
- START -> PORT: 2 bits.
- PORT -> LEN: 4 bits.
- LEN -> DATA if latched len>0, else -> FIN.
REQ-008 DATA SHALL shift out the latched payload LSB first.
- bitsLeft decrements on each enabled edge.
- After the bit sent with bitsLeft=1, enter FIN.
REQ-009 bitsLeft SHALL be loaded with the latched len on entry to DATA and SHALL be 0 in every other state.
REQ-010 FIN SHALL drive serOut=1 and busy=0, and pulse done=1 for exactly one clk.
- The pulse is not gated by clkEn.
- FIN -> IDLE on the next clk edge.
REQ-011 The earliest a new start can be accepted SHALL be the first enabled edge after return to IDLE; frames are back-to-back separated by at least one idle-high bit.
REQ-012 Total busy duration SHALL be 7+len enabled cycles.
REQ-013 Changes on input buses while busy=1 SHALL NOT affect the frame in flight.
REQ-014 dataIn bits at index >= len SHALL never be transmitted.
REQ-015 With clkEn held low, all outputs and state SHALL hold; done does not re-pulse.

Reset
REQ-016 rst=1 on a clk edge SHALL force IDLE regardless of clkEn, including mid-frame.
- Outputs after reset: serOut=1, busy=0, done=0, bitsLeft=0.
- All latched fields clear.
REQ-017 A frame aborted by rst SHALL NOT produce a done pulse.
REQ-018 start asserted together with rst SHALL be ignored.

Structure
REQ-019 A shared package SHALL hold:
- field widths: PORT_W=2, LEN_W=4, DATA_W=15;
- the FSM state encoding;
- IDLE_LEVEL=1.
This package is also used by the downstream receiver datapath.
REQ-020 A sub-module frame_shreg SHALL provide a parallel-load, enable-gated shift register used for the port, length and payload fields; the FSM and bit counter stay in the top.

Verification
REQ-021 The bench SHALL cover these directed scenarios:
- Basic frame: port=2, len=3, dataIn=0x0005, clkEn=1 -> serOut 0,1,0,0,0,1,1,1,0,1, then 1; done one clk after last bit; busy high for 10 cycles.
- Zero-length frame: port=3, len=0 -> serOut 0,1,1,0,0,0,0; no DATA state; done; busy 7 cycles.
- clkEn=1 every 4th clk, port=1, len=15, dataIn=0x7FFF -> each bit held 4 clks; bitsLeft counts 15..1 on SSD; done after 22 enabled cycles.
- start re-asserted mid-frame with port=0 -> ignored, in-flight frame unchanged; dataIn change mid-frame -> no effect.
- rst pulsed during DATA with bitsLeft=5 -> next edge serOut=1, busy=0, bitsLeft=0, no done; a following start sends a full correct frame.
